div_unit: RTL

- Iterative multi-cycle divider for the 54-instruction MIPS core; sits directly downstream of the register file.
- Consumes rdata1 (dividend) and rdata2 (divisor) for DIV/DIVU.
- Produces quotient and remainder for the HI/LO write path (LO=quotient, HI=remainder).
- Control holds the PC/stall while busy is high.

---
 rtl/div_unit.sv | 108 ++++++++++
 1 files changed

// File: rtl/div_unit.sv
// div_unit: iterative restoring divider for DIV/DIVU, quotient to LO and remainder to HI.
// Ports: clk, rst (async, active-low), ena, start, is_signed, dividend, divisor in;
//        busy, done, quotient, remainder out (all registered).
// Optional: DIV_ZERO_DETECT_EN adds div_zero and short-circuits divide-by-zero to a one-cycle result.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
`ifdef DIV_ZERO_DETECT_EN
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
`else
  output logic [WIDTH-1:0] remainder
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q, quotient_q, remainder_q;
  logic             sa_q, sb_q, sgn_q, busy_q, done_q;
  logic [WIDTH:0]   diff_d;
  logic [WIDTH-1:0] a_abs_d, b_abs_d;
  assign a_abs_d = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign b_abs_d = (is_signed && divisor[WIDTH-1]) ? -divisor : divisor;
  // trial subtract of the shifted partial remainder; MSB set means borrow
  assign diff_d = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
`ifdef DIV_ZERO_DETECT_EN
  logic div_zero_q;
  assign div_zero = div_zero_q;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      sgn_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
      div_zero_q  <= 1'b0;
`endif
    end else if (ena) begin
      case (state_q)
        RUN: begin
          if (cnt_q == CNT_W'(WIDTH)) begin
            state_q     <= DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            quotient_q  <= (sgn_q && (sa_q ^ sb_q)) ? -quo_q : quo_q;
            remainder_q <= (sgn_q && sa_q) ? -rem_q : rem_q;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            rem_q <= diff_d[WIDTH] ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]} : diff_d[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], ~diff_d[WIDTH]};
          end
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
`ifdef DIV_ZERO_DETECT_EN
          div_zero_q <= 1'b0;
`endif
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= a_abs_d;
            dvs_q   <= b_abs_d;
            sa_q    <= dividend[WIDTH-1];
            sb_q    <= divisor[WIDTH-1];
            sgn_q   <= is_signed;
`ifdef DIV_ZERO_DETECT_EN
            if (divisor == '0) begin
              state_q     <= DONE;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              quotient_q  <= '0;
              remainder_q <= dividend;
              div_zero_q  <= 1'b1;
            end
`endif
          end
        end
      endcase
    end
  end
endmodule
